calc_cmd_issuer: RTL

- Initiator side of the calculator's cmd/status handshake.
- Accepts keypad codes from the front-end, buffers them in a small FIFO, and presents one code at a time on cmd.
- Issues a code only when the calculator reports ready. Waits for the busy acknowledge, then waits for ready again before issuing the next code.
- Sits between the keypad scanner and the calculator; detects calculator error and handshake timeout.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/cmd_fifo.sv | 66 ++++++
 rtl/calc_cmd_issuer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command path.
// Holds the status encodings returned by the calculator, the keypad command
// codes, and the state type of the command issuer FSM.
package calc_pkg;

  localparam int CMD_W = 4;

  // Status reported by the calculator.
  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_RSVD  = 2'b11;

  // Keypad command codes; 0-9 are plain digits.
  localparam logic [CMD_W-1:0] CMD_ADD  = 4'b1010;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'b1011;
  localparam logic [CMD_W-1:0] CMD_MUL  = 4'b1100;
  localparam logic [CMD_W-1:0] CMD_IDLE = 4'b1101;
  localparam logic [CMD_W-1:0] CMD_EQ   = 4'b1110;
  localparam logic [CMD_W-1:0] CMD_BKSP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT_READY,
    S_ERROR
  } issuer_state_e;

  // The reserved status code is handled exactly like busy.
  function automatic logic status_is_busy(input logic [1:0] st);
    return (st == ST_BUSY) || (st == ST_RSVD);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of keypad codes.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   push_i, din_i  - write din_i when push_i and not full
//   pop_i          - discard head when pop_i and not empty
//   flush_i        - empty the FIFO; wins over push and pop
//   dout_o         - current head, combinational read
//   fill_o         - current occupancy, 0..DEPTH
// Full/empty are decided from the occupancy count, never from pointer
// equality, so the pointers simply wrap.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int FW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [FW-1:0]    fill_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [FW-1:0]    fill_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (fill_q < FW'(DEPTH)) && !flush_i;
  assign pop_ok  = pop_i && (fill_q != '0) && !flush_i;

  // NOTE: the storage array has no reset; only pointers and count do, so the
  // memory maps onto plain flops/RAM and stale data is never observable.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_q + FW'(push_ok) - FW'(pop_ok);
    end
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign fill_o = fill_q;

endmodule

// File: rtl/calc_cmd_issuer.sv
// Initiator side of the calculator cmd/status handshake.
// Buffers keypad codes and issues them one at a time: a code is driven on cmd
// when the calculator is ready, held until busy is seen, and the next code
// waits until ready returns. Calculator errors and handshake timeouts lock
// the block in ERROR until reset.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   key_valid, key_code   - keypad code offered this cycle
//   key_ready             - a key is accepted this cycle if offered
//   key_drop              - offered key rejected this cycle
//   status                - calculator status (00 err, 01 busy, 10 ready, 11 busy)
//   cmd                   - registered command to the calculator
//   busy                  - a command is in flight (DRIVE or WAIT_READY)
//   fill                  - FIFO occupancy
//   error, timeout        - sticky fault flags
module calc_cmd_issuer
  import calc_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               TIMEOUT  = 1024,
  parameter logic [CMD_W-1:0] IDLE_CMD = CMD_IDLE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [CMD_W-1:0]       key_code,
  output logic                   key_ready,
  output logic                   key_drop,
  input  logic [1:0]             status,
  output logic [CMD_W-1:0]       cmd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   error,
  output logic                   timeout
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  issuer_state_e    state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_q, timeout_d;

  logic             push;
  logic             pop;
  logic             flush;
  logic [CMD_W-1:0] fifo_head;
  logic [FW-1:0]    fifo_fill;
  logic             timer_expired;

  // Acceptance depends on registered occupancy only; a pop on the same edge
  // does not make room for this cycle's key.
  assign key_ready = (fifo_fill < FW'(DEPTH)) && (state_q != S_ERROR);
  assign push      = key_valid && key_ready && (key_code != IDLE_CMD);
  assign key_drop  = key_valid && (!key_ready || (key_code == IDLE_CMD));

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (key_code),
    .dout_o  (fifo_head),
    .fill_o  (fifo_fill)
  );

  assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_d = IDLE_CMD;
        if (status == ST_ERR) begin
          state_d = S_ERROR;
        end else if ((fifo_fill != '0) && (status == ST_READY)) begin
          cmd_d   = fifo_head;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (status == ST_ERR) begin
          state_d = S_ERROR;
        end else if (status_is_busy(status)) begin
          // Busy is the acknowledge: the head is consumed here.
          pop     = 1'b1;
          cmd_d   = IDLE_CMD;
          state_d = S_WAIT_READY;
        end else if (timer_expired) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end
      end
      S_WAIT_READY: begin
        if (status == ST_ERR) begin
          state_d = S_ERROR;
        end else if (status == ST_READY) begin
          state_d = S_IDLE;
        end else if (timer_expired) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end
      end
      S_ERROR: begin
        cmd_d = IDLE_CMD;
      end
    endcase

    // Timer restarts on any state change and only runs while a command is
    // in flight.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == S_DRIVE) || (state_q == S_WAIT_READY)) begin
      timer_d = timer_q + TW'(1);
    end

    if (state_d == S_ERROR) begin
      cmd_d = IDLE_CMD;
    end
  end

  // Flushing on the entry edge makes fill read 0 from the first ERROR cycle.
  assign flush = (state_d == S_ERROR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cmd_q     <= IDLE_CMD;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmd     = cmd_q;
  assign busy    = (state_q == S_DRIVE) || (state_q == S_WAIT_READY);
  assign fill    = fifo_fill;
  assign error   = (state_q == S_ERROR);
  assign timeout = timeout_q;

endmodule
